// File: rtl/jbi_ncio_prtq_fifo.sv
// NCIO PIO-return queue: banked FIFO with registered show-ahead head and sticky error flags.
// Define JBI_PRTQ_FIFO_PARITY_EN to add per-bank even parity, checked on the head register.
module jbi_ncio_prtq_fifo #(
  parameter int WIDTH   = 146,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int SLICE_W = 81
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enq_vld_i,
  output logic              enq_rdy_o,
  input  logic [WIDTH-1:0]  enq_data_i,
  output logic              deq_vld_o,
  input  logic              deq_rdy_i,
  output logic [WIDTH-1:0]  deq_data_o,
  input  logic              hold_i,
  output logic [ADDR_W:0]   occ_o,
  output logic              ovf_err_o,
  output logic              udf_err_o,
  output logic              par_err_o
);

  localparam int NSLICE = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              vld_q, vld_d;
  logic [WIDTH-1:0]  head_q, head_d;
  logic [WIDTH-1:0]  rd_word;
  logic              ovf_q, udf_q;
  logic              enq, deq, fwd, enq_rdy;

  assign enq_rdy = (occ_q != FULL);
  assign enq     = enq_vld_i & enq_rdy;
  assign deq     = vld_q & deq_rdy_i & ~hold_i;
  assign fwd     = enq & (wr_ptr_q == rd_ptr_d);

`ifdef JBI_PRTQ_FIFO_PARITY_EN
  logic [NSLICE-1:0] enq_par, rd_par, par_q, par_d, par_bad;
  logic              par_err_q;
`endif

  // The last bank's pad bits are constant zero, so only the real bits are stored.
  for (genvar k = 0; k < NSLICE; k++) begin : g_bank
    localparam int LO = k * SLICE_W;
    localparam int BW = (WIDTH - LO < SLICE_W) ? (WIDTH - LO) : SLICE_W;
`ifdef JBI_PRTQ_FIFO_PARITY_EN
    logic [BW:0] mem_q [DEPTH];
    assign enq_par[k] = ^enq_data_i[LO +: BW];
    always_ff @(posedge clk_i)
      if (enq) mem_q[wr_ptr_q] <= {enq_par[k], enq_data_i[LO +: BW]};
    assign rd_word[LO +: BW] = mem_q[rd_ptr_d][BW-1:0];
    assign rd_par[k]         = mem_q[rd_ptr_d][BW];
    assign par_bad[k]        = ^{par_q[k], head_q[LO +: BW]};
`else
    logic [BW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i)
      if (enq) mem_q[wr_ptr_q] <= enq_data_i[LO +: BW];
    assign rd_word[LO +: BW] = mem_q[rd_ptr_d];
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(enq);
    rd_ptr_d = rd_ptr_q + ADDR_W'(deq);
    occ_d    = occ_q + (ADDR_W+1)'(enq) - (ADDR_W+1)'(deq);
    vld_d    = vld_q;
    head_d   = head_q;
`ifdef JBI_PRTQ_FIFO_PARITY_EN
    par_d    = par_q;
`endif
    // Head tracks mem[rd_ptr_d]; a same-cycle write to that slot is forwarded.
    if (!hold_i) begin
      vld_d = (occ_d != '0);
      if (occ_d != '0) begin
        head_d = fwd ? enq_data_i : rd_word;
`ifdef JBI_PRTQ_FIFO_PARITY_EN
        par_d  = fwd ? enq_par : rd_par;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      vld_q    <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
      ovf_q    <= ovf_q | (enq_vld_i & ~enq_rdy);
      udf_q    <= udf_q | (deq_rdy_i & ~vld_q & ~hold_i);
    end
  end

`ifdef JBI_PRTQ_FIFO_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_q | (vld_q & (|par_bad));
    end
  end
  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif

  assign enq_rdy_o  = enq_rdy;
  assign deq_vld_o  = vld_q;
  assign deq_data_o = head_q;
  assign occ_o      = occ_q;
  assign ovf_err_o  = ovf_q;
  assign udf_err_o  = udf_q;

endmodule
